// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants, challenge codes and the multiplier state encoding.
// Also holds small helpers that map a nonzero challenge entry onto an operand read.
package dilithium_pkg;

   localparam int unsigned Q      = 8380417;
   localparam int          N      = 256;
   localparam int          COEF_W = 24;

   localparam logic [1:0] C_ZERO = 2'd0;
   localparam logic [1:0] C_POS  = 2'd1;
   localparam logic [1:0] C_NEG  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SCAN  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   typedef struct packed {
      logic [7:0] pos;
      logic       neg;
   } nz_entry_t;

   function automatic logic [7:0] operand_addr(input logic [7:0] n, input nz_entry_t e);
      return n - e.pos;
   endfunction

   // X^256 = -1, so a term that wraps past the top flips its sign once more.
   function automatic logic term_negated(input logic [7:0] n, input nz_entry_t e);
      return e.neg ^ (e.pos > n);
   endfunction

endpackage

// File: rtl/challenge_poly_mult_if.sv
// Control and memory-port bundle of the sparse challenge multiplier.
// start is a one-cycle request honoured only in IDLE; done pulses once after w[255] is written; both RAM reads return data the cycle after the address.
interface challenge_poly_mult_if;
   import dilithium_pkg::*;

   logic        start;
   logic        busy;
   logic        done;
   logic [7:0]  c_addr;
   logic [1:0]  c_rdata;
   logic [7:0]  s_addr;
   logic [23:0] s_rdata;
   logic [15:0] w_A;
   logic [23:0] w_D;
   logic        w_WEB;
   logic [6:0]  nz_count;
   logic        err_overflow;
   state_t      state;

   modport master (
      output start, c_rdata, s_rdata,
      input  busy, done, c_addr, s_addr, w_A, w_D, w_WEB, nz_count, err_overflow, state
   );

   modport slave (
      input  start, c_rdata, s_rdata,
      output busy, done, c_addr, s_addr, w_A, w_D, w_WEB, nz_count, err_overflow, state
   );

endinterface

// File: rtl/modq_cond_acc.sv
// acc + (negate ? -operand : operand) mod Q for acc, operand in [0, Q).
// Negating zero yields zero so the result never equals Q.
module modq_cond_acc
   import dilithium_pkg::*;
(
   input  logic [23:0] acc,
   input  logic [23:0] operand,
   input  logic        negate,
   output logic [23:0] sum
);

   logic [23:0] term;
   logic [24:0] raw;

   always_comb begin
      term = operand;
      if (negate && (operand != 24'd0)) term = 24'(Q) - operand;
      raw = {1'b0, acc} + {1'b0, term};
      sum = raw[23:0];
      if (raw >= 25'(Q)) sum = 24'(raw - 25'(Q));
   end

endmodule

// File: rtl/challenge_poly_mult.sv
// Sparse negacyclic multiply w = c*s mod (X^256+1, Q): scan c into a list of
// nonzero +-1 positions, then accumulate one output coefficient per list pass.
module challenge_poly_mult
   import dilithium_pkg::*;
#(
   parameter int MAX_NZ = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   challenge_poly_mult_if.slave  bus
);

   localparam int IDX_W = $clog2(MAX_NZ);

   state_t      state_q;
   nz_entry_t   nz_list [MAX_NZ];
   logic [8:0]  scan_cnt;
   logic        pend_vld;
   logic [7:0]  pend_pos;
   logic [6:0]  issue_idx;
   logic [7:0]  coef_n;
   logic        flip_a, vld_a;
   logic        flip_d, vld_d;
   logic [23:0] acc, acc_sum, acc_next;

   logic        code_nz, has_room, append;
   logic [6:0]  nz_final;
   logic [7:0]  n_next;
   nz_entry_t   new_entry, first_entry, issue_entry;

   assign bus.state = state_q;

   modq_cond_acc u_acc (
      .acc     (acc),
      .operand (bus.s_rdata),
      .negate  (flip_d),
      .sum     (acc_sum)
   );

   always_comb begin
      code_nz     = pend_vld && ((bus.c_rdata == C_POS) || (bus.c_rdata == C_NEG));
      has_room    = bus.nz_count < 7'(MAX_NZ);
      append      = (state_q == ST_SCAN) && code_nz && has_room;
      nz_final    = bus.nz_count + 7'(append);
      new_entry   = '{pos: pend_pos, neg: (bus.c_rdata == C_NEG)};
      // The very last scan edge may be the one that writes entry 0.
      first_entry = (bus.nz_count == 7'd0) ? new_entry : nz_list[0];
      issue_entry = nz_list[issue_idx[IDX_W-1:0]];
      n_next      = coef_n + 8'd1;
      acc_next    = vld_d ? acc_sum : acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         bus.busy         <= 1'b0;
         bus.done         <= 1'b0;
         bus.c_addr       <= 8'd0;
         bus.s_addr       <= 8'd0;
         bus.w_A          <= 16'd0;
         bus.w_D          <= 24'd0;
         bus.w_WEB        <= 1'b1;
         bus.nz_count     <= 7'd0;
         bus.err_overflow <= 1'b0;
         pend_vld         <= 1'b0;
         vld_a            <= 1'b0;
         vld_d            <= 1'b0;
      end else begin
         bus.done  <= 1'b0;
         bus.w_WEB <= 1'b1;
         vld_a     <= 1'b0;
         vld_d     <= vld_a;
         flip_d    <= flip_a;
         acc       <= acc_next;

         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q          <= ST_SCAN;
                  bus.busy         <= 1'b1;
                  bus.nz_count     <= 7'd0;
                  bus.err_overflow <= 1'b0;
                  bus.c_addr       <= 8'd0;
                  scan_cnt         <= 9'd0;
                  pend_vld         <= 1'b0;
                  for (int i = 0; i < MAX_NZ; i++) nz_list[i] <= '0;
               end
            end

            ST_SCAN: begin
               if (code_nz) begin
                  if (has_room) begin
                     nz_list[bus.nz_count[IDX_W-1:0]] <= new_entry;
                     bus.nz_count <= bus.nz_count + 7'd1;
                  end else begin
                     bus.err_overflow <= 1'b1;
                  end
               end
               pend_pos   <= bus.c_addr;
               pend_vld   <= !scan_cnt[8];
               bus.c_addr <= bus.c_addr + 8'd1;
               scan_cnt   <= scan_cnt + 9'd1;
               if (scan_cnt[8]) begin
                  coef_n <= 8'd0;
                  acc    <= 24'd0;
                  if (nz_final != 7'd0) begin
                     state_q    <= ST_ISSUE;
                     bus.s_addr <= operand_addr(8'd0, first_entry);
                     flip_a     <= term_negated(8'd0, first_entry);
                     vld_a      <= 1'b1;
                     issue_idx  <= 7'd1;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end
            end

            ST_ISSUE: begin
               if (issue_idx == bus.nz_count) begin
                  state_q <= ST_DRAIN;
               end else begin
                  bus.s_addr <= operand_addr(coef_n, issue_entry);
                  flip_a     <= term_negated(coef_n, issue_entry);
                  vld_a      <= 1'b1;
                  issue_idx  <= issue_idx + 7'd1;
               end
            end

            ST_DRAIN: begin
               state_q   <= ST_WRITE;
               bus.w_WEB <= 1'b0;
               bus.w_A   <= {8'h00, coef_n};
               bus.w_D   <= acc_next;
            end

            ST_WRITE: begin
               acc <= 24'd0;
               if (coef_n == 8'd255) begin
                  state_q  <= ST_DONE;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  coef_n <= n_next;
                  if (bus.nz_count != 7'd0) begin
                     state_q    <= ST_ISSUE;
                     bus.s_addr <= operand_addr(n_next, nz_list[0]);
                     flip_a     <= term_negated(n_next, nz_list[0]);
                     vld_a      <= 1'b1;
                     issue_idx  <= 7'd1;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end
            end

            ST_DONE: state_q <= ST_IDLE;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_challenge_poly_mult.sv
// Directed bench for challenge_poly_mult: RAM models, in-order write scoreboard
// against hand-computed or schoolbook negacyclic expectations, cycle-exact done.
module tb_challenge_poly_mult;
   import dilithium_pkg::*;

   localparam longint QB = 8380417;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   challenge_poly_mult_if bus ();

   challenge_poly_mult #(.MAX_NZ(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [1:0]  c_mem [256];
   logic [23:0] s_mem [256];
   logic [23:0] exp_q [$];
   int          exp_n;
   int          write_cnt = 0;
   int          n_compared = 0;
   int          n_mismatched = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Synchronous-read RAMs with one cycle of latency.
   always @(posedge clk) begin
      bus.c_rdata <= c_mem[bus.c_addr];
      bus.s_rdata <= s_mem[bus.s_addr];
   end

   // Writes must arrive in order n = 0..255 and match the expected queue.
   always @(negedge clk) begin
      if (bus.w_WEB === 1'b0) begin
         write_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected write", 32'(bus.w_A), 32'hFFFF_FFFF);
         end else begin
            check_eq($sformatf("w_A[%0d]", exp_n), 32'(bus.w_A), 32'(exp_n));
            check_eq($sformatf("w_D[%0d]", exp_n), 32'(bus.w_D), 32'(exp_q.pop_front()));
            exp_n++;
         end
      end
   end

   task automatic clear_mems();
      for (int i = 0; i < 256; i++) begin
         c_mem[i] = 2'd0;
         s_mem[i] = 24'd0;
      end
      exp_q.delete();
      exp_n = 0;
   endtask

   // Schoolbook negacyclic product over the first 'limit' nonzeros of c.
   task automatic build_expected(input int limit);
      longint acc [256];
      longint sgn;
      int     k;
      int     cnt;
      for (int n = 0; n < 256; n++) acc[n] = 0;
      cnt = 0;
      for (int i = 0; i < 256; i++) begin
         if (c_mem[i] == 2'd1 || c_mem[i] == 2'd3) begin
            if (cnt < limit) begin
               for (int j = 0; j < 256; j++) begin
                  k   = i + j;
                  sgn = (c_mem[i] == 2'd3) ? -1 : 1;
                  if (k >= 256) begin
                     k   = k - 256;
                     sgn = -sgn;
                  end
                  acc[k] = (((acc[k] + sgn * longint'(s_mem[j])) % QB) + QB) % QB;
               end
            end
            cnt++;
         end
      end
      exp_q.delete();
      for (int n = 0; n < 256; n++) exp_q.push_back(24'(acc[n]));
      exp_n = 0;
   endtask

   // Edge 0 samples start; cycle k is the interval after edge k-1.
   task automatic run_job(input int poke_a, input int poke_b, input int budget, output int done_cyc);
      int cyc;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 1;
      done_cyc = -1;
      check_eq("busy in cycle 1", 32'(bus.busy), 32'd1);
      while (cyc < budget) begin
         if (bus.done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         bus.start = (cyc == poke_a || cyc == poke_b) ? 1'b1 : 1'b0;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start = 1'b0;
      if (done_cyc < 0) check_eq("done timeout", 32'd0, 32'd1);
      else check_eq("busy with done", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      check_eq("done one cycle", 32'(bus.done), 32'd0);
      check_eq("idle after done", 32'(bus.state), 32'(ST_IDLE));
   endtask

   task automatic setup_tau39();
      int p;
      clear_mems();
      for (int i = 0; i < 256; i += 17) c_mem[i] = 2'd2;
      for (int i = 0; i < 39; i++) begin
         p = (i * 37 + 11) % 256;
         c_mem[p] = (i % 3 == 0) ? 2'd3 : 2'd1;
      end
      for (int i = 0; i < 256; i++) s_mem[i] = 24'($urandom_range(0, 8380416));
   endtask

   task automatic setup_unit_c0();
      clear_mems();
      c_mem[0] = 2'd1;
      for (int n = 0; n < 256; n++) begin
         s_mem[n] = 24'(n + 1);
         exp_q.push_back(24'(n + 1));
      end
   endtask

   initial begin
      int dc;
      int base;
      int cyc;

      rst = 1'b1;
      bus.start = 1'b0;
      clear_mems();
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst busy", 32'(bus.busy), 32'd0);
      check_eq("rst done", 32'(bus.done), 32'd0);
      check_eq("rst c_addr", 32'(bus.c_addr), 32'd0);
      check_eq("rst s_addr", 32'(bus.s_addr), 32'd0);
      check_eq("rst w_A", 32'(bus.w_A), 32'd0);
      check_eq("rst w_D", 32'(bus.w_D), 32'd0);
      check_eq("rst w_WEB", 32'(bus.w_WEB), 32'd1);
      check_eq("rst nz_count", 32'(bus.nz_count), 32'd0);
      check_eq("rst err_overflow", 32'(bus.err_overflow), 32'd0);
      check_eq("rst state", 32'(bus.state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;

      // c = +1 at X^0: w = s
      setup_unit_c0();
      base = write_cnt;
      run_job(-1, -1, 2000, dc);
      check_eq("t1 done cycle", 32'(dc), 32'd1026);
      check_eq("t1 nz_count", 32'(bus.nz_count), 32'd1);
      check_eq("t1 writes", 32'(write_cnt - base), 32'd256);

      // c = +1 at X^1: w[0] = -s[255], w[n] = s[n-1]
      clear_mems();
      c_mem[1] = 2'd1;
      for (int n = 0; n < 256; n++) begin
         s_mem[n] = 24'(n + 1);
         exp_q.push_back((n == 0) ? 24'd8380161 : 24'(n));
      end
      base = write_cnt;
      run_job(-1, -1, 2000, dc);
      check_eq("t2 done cycle", 32'(dc), 32'd1026);
      check_eq("t2 writes", 32'(write_cnt - base), 32'd256);

      // c = -1 at X^0: negating zero must give 0, not Q
      clear_mems();
      c_mem[0] = 2'd3;
      s_mem[1] = 24'd5;
      for (int n = 0; n < 256; n++) exp_q.push_back((n == 1) ? 24'd8380412 : 24'd0);
      base = write_cnt;
      run_job(-1, -1, 2000, dc);
      check_eq("t3 done cycle", 32'(dc), 32'd1026);
      check_eq("t3 nz_count", 32'(bus.nz_count), 32'd1);

      // tau = 39 mixed signs, stray code 2 entries, start pokes while busy
      setup_tau39();
      build_expected(64);
      base = write_cnt;
      run_job(5, 5000, 12000, dc);
      check_eq("t4 done cycle", 32'(dc), 32'd10754);
      check_eq("t4 nz_count", 32'(bus.nz_count), 32'd39);
      check_eq("t4 err_overflow", 32'(bus.err_overflow), 32'd0);
      check_eq("t4 writes", 32'(write_cnt - base), 32'd256);

      // 65 nonzeros: only positions 0..63 contribute
      clear_mems();
      for (int i = 0; i <= 64; i++) c_mem[i] = 2'd1;
      for (int i = 0; i < 256; i++) s_mem[i] = 24'($urandom_range(0, 8380416));
      build_expected(64);
      base = write_cnt;
      run_job(-1, -1, 20000, dc);
      check_eq("t5 done cycle", 32'(dc), 32'd17154);
      check_eq("t5 nz_count", 32'(bus.nz_count), 32'd64);
      check_eq("t5 err_overflow", 32'(bus.err_overflow), 32'd1);
      check_eq("t5 writes", 32'(write_cnt - base), 32'd256);

      // A new start clears the overflow flag
      setup_unit_c0();
      run_job(-1, -1, 2000, dc);
      check_eq("t5b err cleared", 32'(bus.err_overflow), 32'd0);

      // Reset while coefficient 100 is being issued
      setup_tau39();
      build_expected(64);
      base = write_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 0;
      while (!((write_cnt - base) == 100 && bus.state == ST_ISSUE) && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_eq("t6 reached n=100", 32'(cyc < 20000), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("t6 busy after rst", 32'(bus.busy), 32'd0);
      check_eq("t6 w_WEB after rst", 32'(bus.w_WEB), 32'd1);
      check_eq("t6 state after rst", 32'(bus.state), 32'(ST_IDLE));
      exp_q.delete();
      base = write_cnt;
      repeat (400) @(posedge clk);
      #1;
      check_eq("t6 writes after rst", 32'(write_cnt - base), 32'd0);

      // Fresh run after the interrupted one
      setup_unit_c0();
      base = write_cnt;
      run_job(-1, -1, 2000, dc);
      check_eq("t7 done cycle", 32'(dc), 32'd1026);
      check_eq("t7 writes", 32'(write_cnt - base), 32'd256);

      // rst and start together: start is lost
      @(negedge clk);
      rst = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("t8 busy rst+start", 32'(bus.busy), 32'd0);
      check_eq("t8 state rst+start", 32'(bus.state), 32'(ST_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
